// File: rtl/ila_dump.sv
// ILA window dump: buffers one capture window, then streams header, count and payload bytes MSB first.
// All outputs registered; header is valid the cycle after the cap_last sample; bytes hold while out_ready is low.
module ila_dump #(
  parameter int         DATA_WIDTH = 64,
  parameter int         DEPTH_LOG2 = 4,
  parameter logic [7:0] HDR_BYTE   = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_valid,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  cap_last,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  overflow,
  output logic                  frame_done
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int NB    = DATA_WIDTH / 8;
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_HDR, S_CNT, S_SEND, S_DONE
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]         r_count, w_count_nxt;
  logic [DEPTH_LOG2-1:0] r_rd_idx, w_rd_idx_nxt;
  logic [BW-1:0]         r_byte_idx, w_byte_idx_nxt;
  logic                  r_overflow, w_overflow_nxt;
  logic                  w_wr_en;
  logic [DEPTH_LOG2-1:0] w_wr_addr;
  logic                  w_hs, w_last_word;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [7:0]            w_rd_byte;
  logic [7:0]            r_out_data, w_data_nxt;
  logic                  r_out_valid, w_valid_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_frame_done, w_done_nxt;

  assign w_hs        = r_out_valid & out_ready;
  assign w_last_word = ({1'b0, r_rd_idx} == (r_count - CW'(1)));

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_rd_idx_nxt   = r_rd_idx;
    w_byte_idx_nxt = r_byte_idx;
    w_overflow_nxt = r_overflow;
    w_wr_en        = 1'b0;
    w_wr_addr      = '0;
    case (r_state)
      S_IDLE: begin
        if (cap_valid) begin
          w_wr_en        = 1'b1;
          w_count_nxt    = CW'(1);
          w_overflow_nxt = 1'b0;
          w_state_nxt    = cap_last ? S_HDR : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (cap_valid) begin
          if (r_count < FULL) begin
            w_wr_en     = 1'b1;
            w_wr_addr   = r_count[DEPTH_LOG2-1:0];
            w_count_nxt = r_count + CW'(1);
          end else begin
            w_overflow_nxt = 1'b1;
          end
          if (cap_last) w_state_nxt = S_HDR;
        end
      end
      S_HDR: if (w_hs) w_state_nxt = S_CNT;
      S_CNT: begin
        if (w_hs) begin
          w_state_nxt    = S_SEND;
          w_rd_idx_nxt   = '0;
          w_byte_idx_nxt = '0;
        end
      end
      S_SEND: begin
        if (w_hs) begin
          if (r_byte_idx == LAST_BYTE) begin
            w_byte_idx_nxt = '0;
            if (w_last_word) w_state_nxt = S_DONE;
            else             w_rd_idx_nxt = r_rd_idx + DEPTH_LOG2'(1);
          end else begin
            w_byte_idx_nxt = r_byte_idx + BW'(1);
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output registers are loaded from the next state so every output is a flop.
  assign w_rd_word = r_mem[w_rd_idx_nxt];

  always_comb begin
    w_rd_byte = '0;
    for (int b = 0; b < NB; b++)
      if (BW'(b) == w_byte_idx_nxt) w_rd_byte = w_rd_word[DATA_WIDTH-1-8*b -: 8];
  end

  always_comb begin
    w_data_nxt  = '0;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = 1'b1;
    w_done_nxt  = 1'b0;
    case (w_state_nxt)
      S_IDLE: w_busy_nxt = 1'b0;
      S_HDR: begin
        w_valid_nxt = 1'b1;
        w_data_nxt  = HDR_BYTE;
      end
      S_CNT: begin
        w_valid_nxt = 1'b1;
        w_data_nxt  = 8'(w_count_nxt);
      end
      S_SEND: begin
        w_valid_nxt = 1'b1;
        w_data_nxt  = w_rd_byte;
      end
      S_DONE:  w_done_nxt = 1'b1;
      default: w_busy_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst && w_wr_en) r_mem[w_wr_addr] <= cap_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_rd_idx     <= '0;
      r_byte_idx   <= '0;
      r_overflow   <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_rd_idx     <= w_rd_idx_nxt;
      r_byte_idx   <= w_byte_idx_nxt;
      r_overflow   <= w_overflow_nxt;
      r_out_data   <= w_data_nxt;
      r_out_valid  <= w_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_done_nxt;
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign overflow   = r_overflow;
  assign frame_done = r_frame_done;
endmodule
